// File: rtl/reg_writeback_ctrl_if.sv
// Register writeback bus: ALU result, memory-result handshake, register-bank
// write port, forwarding lookup and queue occupancy.
interface reg_writeback_ctrl_if;
  // M handshake: a result transfers on a rising edge where M_Valid && M_Ready.
  // M_Ready depends only on queue state, never on M_Valid. A has no backpressure.
  logic        A_Valid;
  logic [4:0]  A_Reg;
  logic [31:0] A_Data;
  logic        M_Valid;
  logic        M_Ready;
  logic [4:0]  M_Reg;
  logic [31:0] M_Data;
  logic        RegWrite;
  logic [4:0]  Write_Reg;
  logic [31:0] Write_Data;
  logic [4:0]  Fwd_Reg1;
  logic [4:0]  Fwd_Reg2;
  logic        Fwd_Hit1;
  logic        Fwd_Hit2;
  logic [31:0] Fwd_Data1;
  logic [31:0] Fwd_Data2;
  logic [4:0]  Q_Count;

  modport slave (
    input  A_Valid, A_Reg, A_Data, M_Valid, M_Reg, M_Data, Fwd_Reg1, Fwd_Reg2,
    output M_Ready, RegWrite, Write_Reg, Write_Data, Fwd_Hit1, Fwd_Hit2,
           Fwd_Data1, Fwd_Data2, Q_Count
  );

  modport master (
    output A_Valid, A_Reg, A_Data, M_Valid, M_Reg, M_Data, Fwd_Reg1, Fwd_Reg2,
    input  M_Ready, RegWrite, Write_Reg, Write_Data, Fwd_Hit1, Fwd_Hit2,
           Fwd_Data1, Fwd_Data2, Q_Count
  );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// Writeback arbiter: ALU results win, memory results wait in a small queue.
// Optional forwarding lookup is built when macro WB_FORWARD_EN is defined.
module reg_writeback_ctrl #(
   parameter int FIFO_DEPTH = 4
) (
   input logic                  Clk,
   input logic                  Rst_n,
   reg_writeback_ctrl_if.slave  bus
);

   localparam int         PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

   logic [4:0]            ent_reg_q  [FIFO_DEPTH];
   logic [4:0]            ent_reg_d  [FIFO_DEPTH];
   logic [31:0]           ent_data_q [FIFO_DEPTH];
   logic [31:0]           ent_data_d [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] ent_live_q, ent_live_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [4:0]            count_q, count_d;
   logic                  ready_en_q, ready_en_d;
   logic                  regwrite_q, regwrite_d;
   logic [4:0]            write_reg_q, write_reg_d;
   logic [31:0]           write_data_q, write_data_d;

   logic a_req;
   logic full;
   logic m_ready;
   logic enq;
   logic pop;

   // A with register 0 is treated as idle so the queue can drain that cycle.
   assign a_req   = bus.A_Valid && (bus.A_Reg != 5'd0);
   assign full    = (count_q == DEPTH_C);
   assign m_ready = ready_en_q && !full;
   assign enq     = bus.M_Valid && m_ready && (bus.M_Reg != 5'd0);
   assign pop     = !a_req && (count_q != 5'd0);

   always_comb begin
      ent_reg_d    = ent_reg_q;
      ent_data_d   = ent_data_q;
      ent_live_d   = ent_live_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      ready_en_d   = 1'b1;
      regwrite_d   = 1'b0;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;

      if (a_req) begin
         regwrite_d   = 1'b1;
         write_reg_d  = bus.A_Reg;
         write_data_d = bus.A_Data;
         // Older queued results for this register must never land after A.
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_reg_q[i] == bus.A_Reg) ent_live_d[i] = 1'b0;
         end
      end else if (pop) begin
         regwrite_d = ent_live_q[rd_ptr_q];
         if (ent_live_q[rd_ptr_q]) begin
            write_reg_d  = ent_reg_q[rd_ptr_q];
            write_data_d = ent_data_q[rd_ptr_q];
         end
         rd_ptr_d = rd_ptr_q + PW'(1);
      end

      if (enq) begin
         ent_reg_d[wr_ptr_q]  = bus.M_Reg;
         ent_data_d[wr_ptr_q] = bus.M_Data;
         ent_live_d[wr_ptr_q] = !(a_req && (bus.M_Reg == bus.A_Reg));
         wr_ptr_d             = wr_ptr_q + PW'(1);
      end

      count_d = count_q + {4'd0, enq} - {4'd0, pop};
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            ent_reg_q[i]  <= 5'd0;
            ent_data_q[i] <= 32'd0;
         end
         ent_live_q   <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= 5'd0;
         ready_en_q   <= 1'b0;
         regwrite_q   <= 1'b0;
         write_reg_q  <= 5'd0;
         write_data_q <= 32'd0;
      end else begin
         ent_reg_q    <= ent_reg_d;
         ent_data_q   <= ent_data_d;
         ent_live_q   <= ent_live_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         ready_en_q   <= ready_en_d;
         regwrite_q   <= regwrite_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   assign bus.M_Ready    = m_ready;
   assign bus.RegWrite   = regwrite_q;
   assign bus.Write_Reg  = write_reg_q;
   assign bus.Write_Data = write_data_q;
   assign bus.Q_Count    = count_q;

`ifdef WB_FORWARD_EN
   logic [4:0]    fwd_reg  [2];
   logic          fwd_hit  [2];
   logic [31:0]   fwd_data [2];
   logic [PW-1:0] fwd_idx;

   // Checked lowest priority first so later matches override earlier ones;
   // walking the queue oldest to youngest leaves the youngest live match.
   always_comb begin
      fwd_reg[0] = bus.Fwd_Reg1;
      fwd_reg[1] = bus.Fwd_Reg2;
      fwd_idx    = '0;
      for (int p = 0; p < 2; p++) begin
         fwd_hit[p]  = 1'b0;
         fwd_data[p] = 32'd0;
         if (ready_en_q && (fwd_reg[p] != 5'd0)) begin
            if (regwrite_q && (write_reg_q == fwd_reg[p])) begin
               fwd_hit[p]  = 1'b1;
               fwd_data[p] = write_data_q;
            end
            for (int k = 0; k < FIFO_DEPTH; k++) begin
               fwd_idx = rd_ptr_q + PW'(k);
               if ((k < int'(count_q)) && ent_live_q[fwd_idx] &&
                   (ent_reg_q[fwd_idx] == fwd_reg[p])) begin
                  fwd_hit[p]  = 1'b1;
                  fwd_data[p] = ent_data_q[fwd_idx];
               end
            end
            if (a_req && (bus.A_Reg == fwd_reg[p])) begin
               fwd_hit[p]  = 1'b1;
               fwd_data[p] = bus.A_Data;
            end
         end
      end
   end

   assign bus.Fwd_Hit1  = fwd_hit[0];
   assign bus.Fwd_Hit2  = fwd_hit[1];
   assign bus.Fwd_Data1 = fwd_data[0];
   assign bus.Fwd_Data2 = fwd_data[1];
`else
   logic unused_fwd;
   assign unused_fwd    = ^{bus.Fwd_Reg1, bus.Fwd_Reg2};
   assign bus.Fwd_Hit1  = 1'b0;
   assign bus.Fwd_Hit2  = 1'b0;
   assign bus.Fwd_Data1 = 32'd0;
   assign bus.Fwd_Data2 = 32'd0;
`endif

endmodule
